// File: rtl/phy_tx_lane_sched.sv
// Link-state sequencer (RST/TRAIN/ACTIVE) and 4-lane round-robin byte scheduler for the PHY transmitter.
// Optional transfer statistics counter enabled by defining PHY_TX_SCHED_STATS_EN.
module phy_tx_lane_sched #(
  parameter logic [7:0]  COM_SYM     = 8'hBC,
  parameter logic [7:0]  IDLE_SYM    = 8'h7C,
  parameter int unsigned TRAIN_LEN   = 4,
  parameter int unsigned ACTIVE_HOLD = 2,
  parameter int unsigned LOSS_LEN    = 4
) (
  input  logic        clk4f,
  input  logic        reset,
  input  logic [7:0]  in0,
  input  logic [7:0]  in1,
  input  logic [7:0]  in2,
  input  logic [7:0]  in3,
  input  logic [3:0]  valid_in,
  output logic [3:0]  ready_out,
  input  logic        active_rx,
  output logic [7:0]  out,
  output logic        validout,
  output logic [1:0]  grant,
`ifdef PHY_TX_SCHED_STATS_EN
  output logic [15:0] xfer_cnt,
`endif
  output logic [1:0]  state
);

  localparam logic [3:0] TRAIN_LIM = 4'(TRAIN_LEN);
  localparam logic [3:0] HOLD_LIM  = 4'(ACTIVE_HOLD);
  localparam logic [3:0] LOSS_LIM  = 4'(LOSS_LEN);
  localparam logic [3:0] LOSS_TRIG = 4'(LOSS_LEN - 1);

  typedef enum logic [1:0] {
    ST_RST    = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_ACTIVE = 2'd2
  } st_t;

  st_t        st_q, st_d;
  logic [3:0] train_cnt, act_cnt, loss_cnt;
  logic [1:0] last_grant;
  logic [1:0] gnt_idx, cand;
  logic       gnt_vld, xfer;
  logic [7:0] sel_byte;
  logic [7:0] out_p1;
  logic       vld_p1;
  logic [1:0] grant_p1;

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

  // State register
  always_ff @(posedge clk4f or posedge reset) begin
    if (reset) st_q <= ST_RST;
    else       st_q <= st_d;
  end

  // Next-state logic; loss exit fires on the cycle that completes LOSS_LEN idle-rx cycles
  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_RST:    st_d = ST_TRAIN;
      ST_TRAIN:  if (train_cnt >= TRAIN_LIM && act_cnt >= HOLD_LIM) st_d = ST_ACTIVE;
      ST_ACTIVE: if (!active_rx && loss_cnt >= LOSS_TRIG) st_d = ST_TRAIN;
      default:   st_d = ST_RST;
    endcase
  end

  // Round-robin search starting one past the last granted lane
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    cand    = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant + 2'(k);
      if (!gnt_vld && valid_in[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Output logic
  always_comb begin
    ready_out = 4'b0000;
    if (st_q == ST_ACTIVE && gnt_vld) ready_out = 4'b0001 << gnt_idx;
    xfer = |(ready_out & valid_in);
    case (gnt_idx)
      2'd0:    sel_byte = in0;
      2'd1:    sel_byte = in1;
      2'd2:    sel_byte = in2;
      default: sel_byte = in3;
    endcase
  end

  // train_cnt counts COM bytes put on out, so the RST edge (which emits the first COM) counts too
  always_ff @(posedge clk4f or posedge reset) begin
    if (reset) begin
      train_cnt <= 4'd0;
      act_cnt   <= 4'd0;
      loss_cnt  <= 4'd0;
    end else begin
      case (st_q)
        ST_RST: begin
          train_cnt <= sat_inc(train_cnt, TRAIN_LIM);
          act_cnt   <= 4'd0;
          loss_cnt  <= 4'd0;
        end
        ST_TRAIN: begin
          train_cnt <= sat_inc(train_cnt, TRAIN_LIM);
          act_cnt   <= active_rx ? sat_inc(act_cnt, HOLD_LIM) : 4'd0;
          loss_cnt  <= 4'd0;
        end
        ST_ACTIVE: begin
          if (st_d == ST_TRAIN) begin
            train_cnt <= 4'd0;
            act_cnt   <= 4'd0;
            loss_cnt  <= 4'd0;
          end else begin
            loss_cnt <= active_rx ? 4'd0 : sat_inc(loss_cnt, LOSS_LIM);
          end
        end
        default: begin
          train_cnt <= 4'd0;
          act_cnt   <= 4'd0;
          loss_cnt  <= 4'd0;
        end
      endcase
    end
  end

  // Stage p1: registered byte toward the serializer; a granted byte wins over COM/IDLE fill
  always_ff @(posedge clk4f or posedge reset) begin
    if (reset) begin
      out_p1     <= 8'h00;
      vld_p1     <= 1'b0;
      grant_p1   <= 2'd0;
      last_grant <= 2'd3;
    end else if (xfer) begin
      out_p1     <= sel_byte;
      vld_p1     <= 1'b1;
      grant_p1   <= gnt_idx;
      last_grant <= gnt_idx;
    end else begin
      vld_p1 <= 1'b0;
      case (st_d)
        ST_TRAIN:  out_p1 <= COM_SYM;
        ST_ACTIVE: out_p1 <= IDLE_SYM;
        default:   out_p1 <= 8'h00;
      endcase
    end
  end

`ifdef PHY_TX_SCHED_STATS_EN
  always_ff @(posedge clk4f or posedge reset) begin
    if (reset)     xfer_cnt <= 16'h0000;
    else if (xfer) xfer_cnt <= xfer_cnt + 16'h0001;
  end
`endif

  assign out      = out_p1;
  assign validout = vld_p1;
  assign grant    = grant_p1;
  assign state    = st_q;

endmodule

// File: tb/tb_phy_tx_lane_sched.sv
// Directed self-checking bench for phy_tx_lane_sched: bring-up, hold-off, round-robin, skip, link loss, async reset.
// Defining PHY_TX_SCHED_STATS_EN also exercises the xfer_cnt wrap.
module tb_phy_tx_lane_sched;

  logic       clk4f = 1'b0;
  logic       reset;
  logic [7:0] in0, in1, in2, in3;
  logic [3:0] valid_in;
  logic [3:0] ready_out;
  logic       active_rx;
  logic [7:0] out;
  logic       validout;
  logic [1:0] grant;
  logic [1:0] state;
`ifdef PHY_TX_SCHED_STATS_EN
  logic [15:0] xfer_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk4f = ~clk4f;

  phy_tx_lane_sched dut (
    .clk4f     (clk4f),
    .reset     (reset),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .active_rx (active_rx),
    .out       (out),
    .validout  (validout),
    .grant     (grant),
`ifdef PHY_TX_SCHED_STATS_EN
    .xfer_cnt  (xfer_cnt),
`endif
    .state     (state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk4f);
    #1;
  endtask

  task automatic wait_active(input string tag);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      tick();
      if (state == 2'd2) hit = 1'b1;
    end
    chk(tag, {31'd0, hit}, 32'd1);
  endtask

  logic [5:0] rx_pat;
  logic [1:0] skip_exp [3];

  initial begin
    reset = 1'b1; active_rx = 1'b1; valid_in = 4'h0;
    in0 = 8'hA0; in1 = 8'hA1; in2 = 8'hA2; in3 = 8'hA3;
    rx_pat = 6'b110101;  // applied LSB first: 1,0,1,0,1,1
    skip_exp[0] = 2'd3; skip_exp[1] = 2'd1; skip_exp[2] = 2'd3;

    // Reset values
    #12;
    chk("rst_out",   {24'd0, out},       32'h00);
    chk("rst_vld",   {31'd0, validout},  32'd0);
    chk("rst_state", {30'd0, state},     32'd0);
    chk("rst_grant", {30'd0, grant},     32'd0);
    chk("rst_ready", {28'd0, ready_out}, 32'd0);

    // Bring-up with active_rx held high
    reset = 1'b0;
    #1;
    chk("rst_cycle_state", {30'd0, state}, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("bringup_state", {30'd0, state},    32'd1);
      chk("bringup_out",   {24'd0, out},      32'hBC);
      chk("bringup_vld",   {31'd0, validout}, 32'd0);
      tick();
    end
    chk("bringup_active", {30'd0, state}, 32'd2);
    chk("bringup_idle",   {24'd0, out},   32'h7C);

    // Hold-off: toggling active_rx keeps the link in TRAIN
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      active_rx = rx_pat[i];
      chk("holdoff_state", {30'd0, state}, 32'd1);
      chk("holdoff_out",   {24'd0, out},   32'hBC);
      tick();
    end
    chk("holdoff_last_train", {30'd0, state}, 32'd1);
    tick();
    chk("holdoff_active", {30'd0, state}, 32'd2);
    chk("holdoff_idle",   {24'd0, out},   32'h7C);

    // Round-robin with all lanes valid
    valid_in = 4'hF;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rr_ready", {28'd0, ready_out}, 32'(4'b0001 << (i % 4)));
      tick();
      chk("rr_out",   {24'd0, out},      32'hA0 + 32'(i % 4));
      chk("rr_grant", {30'd0, grant},    32'(i % 4));
      chk("rr_vld",   {31'd0, validout}, 32'd1);
    end

    // Sparse lanes: bring last_grant to 1, then 4'b1010 skips lanes 0 and 2
    valid_in = 4'b0010;
    #1;
    chk("skip_pre_ready", {28'd0, ready_out}, 32'h2);
    tick();
    chk("skip_pre_grant", {30'd0, grant}, 32'd1);
    valid_in = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("skip_ready", {28'd0, ready_out}, 32'(4'b0001 << skip_exp[i]));
      tick();
      chk("skip_grant", {30'd0, grant}, 32'(skip_exp[i]));
      chk("skip_out",   {24'd0, out},   32'hA0 + 32'(skip_exp[i]));
    end
    valid_in = 4'h0;
    #1;
    chk("idle_ready", {28'd0, ready_out}, 32'd0);
    tick();
    chk("idle_out",   {24'd0, out},      32'h7C);
    chk("idle_vld",   {31'd0, validout}, 32'd0);
    chk("idle_grant", {30'd0, grant},    32'd3);

    // Link loss while lane 2 streams
    valid_in = 4'b0100;
    active_rx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("loss_pre_state", {30'd0, state},     32'd2);
      chk("loss_ready",     {28'd0, ready_out}, 32'h4);
      tick();
      chk("loss_out",   {24'd0, out},      32'hA2);
      chk("loss_vld",   {31'd0, validout}, 32'd1);
      chk("loss_state", {30'd0, state},    (i == 3) ? 32'd1 : 32'd2);
    end
    #1;
    chk("loss_train_ready", {28'd0, ready_out}, 32'd0);
    tick();
    chk("loss_com",   {24'd0, out},      32'hBC);
    chk("loss_com_v", {31'd0, validout}, 32'd0);
    chk("loss_com_s", {30'd0, state},    32'd1);

    // Async reset between edges while ACTIVE
    active_rx = 1'b1;
    valid_in = 4'h0;
    wait_active("reach_active");
    valid_in = 4'hF;
    tick();
    chk("pre_areset_vld", {31'd0, validout}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_out",   {24'd0, out},       32'h00);
    chk("areset_vld",   {31'd0, validout},  32'd0);
    chk("areset_state", {30'd0, state},     32'd0);
    chk("areset_ready", {28'd0, ready_out}, 32'd0);
    chk("areset_grant", {30'd0, grant},     32'd0);
`ifdef PHY_TX_SCHED_STATS_EN
    chk("areset_xfer",  {16'd0, xfer_cnt},  32'd0);

    // Statistics wrap: 65535 transfers reach FFFF, the next one wraps to 0
    valid_in = 4'h0;
    #2;
    reset = 1'b0;
    wait_active("stats_active");
    valid_in = 4'hF;
    repeat (65535) tick();
    chk("xfer_ffff", {16'd0, xfer_cnt}, 32'hFFFF);
    tick();
    chk("xfer_wrap", {16'd0, xfer_cnt}, 32'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
